// File: rtl/dram_resp.sv
// dram_resp: single-port word-addressed memory model answering a
// request/response bus with a fixed, parameterised latency.
//
// Requests are accepted combinationally (dram_addr_ok) while fewer than
// MAX_OUT responses are outstanding, or when a response leaves in the same
// cycle. Every accepted request, read or write, produces one dram_data_ok
// pulse exactly LATENCY cycles later, in acceptance order.
//
// Optional feature: define DRAM_ERR_EN to add the dram_err output. With it,
// addresses at or beyond the array size are answered with dram_err=1 and
// never written. Without it, such addresses alias modulo the array size.
//
// Ports:
//   clk          rising-edge clock
//   rst_b        synchronous active-low reset
//   dram_req     request valid
//   dram_write   1 = write, 0 = read
//   dram_wstrb   byte-lane write enables (writes only)
//   dram_addr    byte address; bits [1:0] do not select the word
//   dram_wdata   write data
//   dram_addr_ok request accepted this cycle
//   dram_data_ok response valid this cycle
//   dram_rdata   read data (0 for write responses and when idle)
//   dram_err     (DRAM_ERR_EN only) response is for an out-of-range address
module dram_resp #(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2,
  parameter int MAX_OUT    = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        dram_req,
  input  logic        dram_write,
  input  logic [3:0]  dram_wstrb,
  input  logic [31:0] dram_addr,
  input  logic [31:0] dram_wdata,
  output logic        dram_addr_ok,
  output logic        dram_data_ok,
  output logic [31:0] dram_rdata
`ifdef DRAM_ERR_EN
  ,
  output logic        dram_err
`endif
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [31:0]           mem [WORDS];
  logic [DEPTH_LOG2-1:0] idx;
  logic [3:0]            out_cnt;
  logic                  accept;
  logic                  in_range;
  logic [31:0]           resp_word;

  // Response delay line: stage LATENCY-1 is the one presented on the bus.
  logic [LATENCY-1:0]    vld;
  logic [31:0]           dat [LATENCY];
`ifdef DRAM_ERR_EN
  logic [LATENCY-1:0]    errq;
`endif

  // Byte-offset bits and (without the error option) the upper address bits
  // play no part in word selection.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dram_addr[31:DEPTH_LOG2+2], dram_addr[1:0]};

  assign idx = dram_addr[DEPTH_LOG2+1:2];

`ifdef DRAM_ERR_EN
  assign in_range = (dram_addr[31:DEPTH_LOG2+2] == '0);
`else
  assign in_range = 1'b1;
`endif

  assign dram_data_ok = vld[LATENCY-1];
  assign dram_rdata   = vld[LATENCY-1] ? dat[LATENCY-1] : '0;
`ifdef DRAM_ERR_EN
  assign dram_err     = vld[LATENCY-1] & errq[LATENCY-1];
`endif

  // A slot frees up in the same cycle a response leaves, so a full pipe can
  // still accept back-to-back.
  always_comb begin
    accept = 1'b0;
    if (rst_b && dram_req && ((out_cnt < 4'(MAX_OUT)) || dram_data_ok)) begin
      accept = 1'b1;
    end
  end
  assign dram_addr_ok = accept;

  // Read data is captured from the array before this edge's write lands,
  // which matches the memory's view at the accept edge.
  always_comb begin
    resp_word = '0;
    if (!dram_write && in_range) begin
      resp_word = mem[idx];
    end
  end

  // Array: never reset; accept is already gated by rst_b.
  always_ff @(posedge clk) begin
    if (accept && dram_write && in_range) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (dram_wstrb[b]) begin
          mem[idx][8*b +: 8] <= dram_wdata[8*b +: 8];
        end
      end
    end
  end

  // Control state: valid bits and outstanding count.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      vld     <= '0;
      out_cnt <= '0;
    end else begin
      vld[0] <= accept;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
      end
      case ({accept, dram_data_ok})
        2'b10:   out_cnt <= out_cnt + 4'd1;
        2'b01:   out_cnt <= out_cnt - 4'd1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Payload: no reset needed, the output is qualified by the valid bit.
  always_ff @(posedge clk) begin
    dat[0] <= resp_word;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      dat[i] <= dat[i-1];
    end
  end

`ifdef DRAM_ERR_EN
  always_ff @(posedge clk) begin
    errq[0] <= ~in_range;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      errq[i] <= errq[i-1];
    end
  end
`endif

endmodule

// File: tb/tb_dram_resp.sv
// Testbench for dram_resp. Three instances share one clock and reset:
//   u0: LATENCY=2 MAX_OUT=2, driven by stimulus set 0
//   u1: LATENCY=3 MAX_OUT=1, driven by stimulus set 1
//   u2: LATENCY=4 MAX_OUT=4, driven by stimulus set 0 (same as u0)
// All use DEPTH_LOG2=4 (16 words).
module tb_dram_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b;
  logic        req0, wr0, req1, wr1;
  logic [3:0]  strb0, strb1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        aok0, dok0, aok1, dok1, aok2, dok2;
  logic [31:0] rd0, rd1, rd2;
`ifdef DRAM_ERR_EN
  logic        err0, err1, err2;
`endif

  dram_resp #(.DEPTH_LOG2(4), .LATENCY(2), .MAX_OUT(2)) u0 (
    .clk(clk), .rst_b(rst_b), .dram_req(req0), .dram_write(wr0),
    .dram_wstrb(strb0), .dram_addr(addr0), .dram_wdata(wdata0),
    .dram_addr_ok(aok0), .dram_data_ok(dok0), .dram_rdata(rd0)
`ifdef DRAM_ERR_EN
    , .dram_err(err0)
`endif
  );

  dram_resp #(.DEPTH_LOG2(4), .LATENCY(3), .MAX_OUT(1)) u1 (
    .clk(clk), .rst_b(rst_b), .dram_req(req1), .dram_write(wr1),
    .dram_wstrb(strb1), .dram_addr(addr1), .dram_wdata(wdata1),
    .dram_addr_ok(aok1), .dram_data_ok(dok1), .dram_rdata(rd1)
`ifdef DRAM_ERR_EN
    , .dram_err(err1)
`endif
  );

  dram_resp #(.DEPTH_LOG2(4), .LATENCY(4), .MAX_OUT(4)) u2 (
    .clk(clk), .rst_b(rst_b), .dram_req(req0), .dram_write(wr0),
    .dram_wstrb(strb0), .dram_addr(addr0), .dram_wdata(wdata0),
    .dram_addr_ok(aok2), .dram_data_ok(dok2), .dram_rdata(rd2)
`ifdef DRAM_ERR_EN
    , .dram_err(err2)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending responses are a single list tagged by instance and due cycle.
  typedef struct {
    int          inst;
    int          due;
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t     q[$];
  resp_t     nq[$];
  resp_t     ent;
  bit [31:0] mm [3][16];
  int        lat_k [3] = '{2, 3, 4};
  int        max_k [3] = '{2, 1, 4};
  int        cyc = 0;
  bit        chk_en = 1'b0;

  logic        m_rq, m_w, m_aok, m_dok;
  logic [3:0]  m_s;
  logic [31:0] m_a, m_d, m_rd;
`ifdef DRAM_ERR_EN
  logic        m_er;
`endif
  int          hit, n, widx;
  logic        e_dok, e_aok, e_err;
  logic [31:0] e_rd;
  bit          inr;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        if (k == 1) begin
          m_rq = req1; m_w = wr1; m_s = strb1; m_a = addr1; m_d = wdata1;
        end else begin
          m_rq = req0; m_w = wr0; m_s = strb0; m_a = addr0; m_d = wdata0;
        end
        case (k)
          0: begin m_aok = aok0; m_dok = dok0; m_rd = rd0; end
          1: begin m_aok = aok1; m_dok = dok1; m_rd = rd1; end
          default: begin m_aok = aok2; m_dok = dok2; m_rd = rd2; end
        endcase
`ifdef DRAM_ERR_EN
        case (k)
          0: m_er = err0;
          1: m_er = err1;
          default: m_er = err2;
        endcase
`endif
        hit = -1;
        n   = 0;
        foreach (q[j]) begin
          if (q[j].inst == k) begin
            n++;
            if (q[j].due == cyc) hit = j;
          end
        end
        e_dok = (hit >= 0);
        e_rd  = (hit >= 0) ? q[hit].data : 32'h0;
        e_err = (hit >= 0) ? q[hit].err : 1'b0;
        e_aok = rst_b && m_rq && (n < max_k[k] || e_dok);

        chk($sformatf("u%0d_addr_ok", k), 32'(m_aok), 32'(e_aok));
        chk($sformatf("u%0d_data_ok", k), 32'(m_dok), 32'(e_dok));
        chk($sformatf("u%0d_rdata", k), m_rd, e_rd);
`ifdef DRAM_ERR_EN
        chk($sformatf("u%0d_err", k), 32'(m_er), 32'(e_err));
`endif

        if (hit >= 0) q.delete(hit);
        if (!rst_b) begin
          nq.delete();
          foreach (q[j]) if (q[j].inst != k) nq.push_back(q[j]);
          q = nq;
        end else if (e_aok) begin
          widx = int'((m_a >> 2) % 32'd16);
`ifdef DRAM_ERR_EN
          inr = (m_a < 32'd64);
`else
          inr = 1'b1;
`endif
          ent.inst = k;
          ent.due  = cyc + lat_k[k];
          ent.data = (!m_w && inr) ? mm[k][widx] : 32'h0;
          ent.err  = !inr;
          q.push_back(ent);
          if (m_w && inr) begin
            for (int b = 0; b < 4; b++) begin
              if (m_s[b]) mm[k][widx][8*b +: 8] = m_d[8*b +: 8];
            end
          end
        end
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Present one request on set k and hold it until accepted (bounded).
  task automatic drive(input int k, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    bit ok = 1'b0;
    if (k == 0) begin
      req0 = 1'b1; wr0 = w; strb0 = s; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; wr1 = w; strb1 = s; addr1 = a; wdata1 = d;
    end
    for (int t = 0; t < 32 && !ok; t++) begin
      @(negedge clk);
      ok = (k == 0) ? bit'(aok0) : bit'(aok1);
    end
    if (!ok) chk($sformatf("u%0d_accept_timeout", k), 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (k == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_b = 1'b0;
    req0 = 1'b1; wr0 = 1'b1; strb0 = 4'hF; addr0 = '0; wdata0 = 32'hDEAD_DEAD;
    req1 = 1'b0; wr1 = 1'b0; strb1 = 4'h0; addr1 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    // Reset state: request held high yet nothing accepted.
    @(negedge clk);
    chk("rst_addr_ok", 32'(aok0), 32'd0);
    chk("rst_data_ok", 32'(dok0), 32'd0);
    chk("rst_rdata", rd0, 32'h0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    req0 = 1'b0;

    // Fill both memories with known words.
    for (int i = 0; i < 16; i++) drive(0, 1'b1, 4'hF, 32'(i * 4), 32'hC0DE_0000 | 32'(i));
    for (int i = 0; i < 16; i++) drive(1, 1'b1, 4'hF, 32'(i * 4), 32'hBEEF_0000 | 32'(i));
    idle(6);

    // Back-to-back reads A,B,C: responses on consecutive cycles, in order.
    drive(0, 1'b0, 4'h0, 32'h4, 32'h0);
    drive(0, 1'b0, 4'h0, 32'h8, 32'h0);
    drive(0, 1'b0, 4'h0, 32'hC, 32'h0);
    @(negedge clk);
    chk("order_b_ok", 32'(dok0), 32'd1);
    chk("order_b_data", rd0, 32'hC0DE_0002);
    @(negedge clk);
    chk("order_c_ok", 32'(dok0), 32'd1);
    chk("order_c_data", rd0, 32'hC0DE_0003);
    @(negedge clk);
    chk("order_end_ok", 32'(dok0), 32'd0);
    idle(3);

    // Byte-lane write then read back on the next cycle.
    drive(0, 1'b1, 4'b1111, 32'h10, 32'h1122_3344);
    drive(0, 1'b1, 4'b0001, 32'h10, 32'h0000_00AA);
    drive(0, 1'b0, 4'b0000, 32'h10, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("lane_ok", 32'(dok0), 32'd1);
    chk("lane_data", rd0, 32'h1122_33AA);
    idle(6);

    // Single write: one pulse LATENCY later with zero data.
    drive(0, 1'b1, 4'hF, 32'h20, 32'h1234_5678);
    @(negedge clk);
    chk("wr_resp_early", 32'(dok0), 32'd0);
    @(negedge clk);
    chk("wr_resp_ok", 32'(dok0), 32'd1);
    chk("wr_resp_data", rd0, 32'h0);
    @(negedge clk);
    chk("wr_resp_once", 32'(dok0), 32'd0);
    idle(6);

    // Out-of-range write then read word 0.
    drive(0, 1'b1, 4'hF, 32'h40, 32'h5566_7788);
    drive(0, 1'b0, 4'h0, 32'h00, 32'h0);
    @(negedge clk);
    chk("oor_wr_data", rd0, 32'h0);
`ifdef DRAM_ERR_EN
    chk("oor_wr_err", 32'(err0), 32'd1);
`endif
    @(negedge clk);
    chk("oor_rd_ok", 32'(dok0), 32'd1);
`ifdef DRAM_ERR_EN
    chk("oor_rd_data", rd0, 32'hC0DE_0000);
    chk("oor_rd_err", 32'(err0), 32'd0);
`else
    chk("alias_rd_data", rd0, 32'h5566_7788);
`endif
    idle(6);

    // Throttling on u1 with the request held high.
    req1 = 1'b1; wr1 = 1'b0; strb1 = 4'h0; addr1 = 32'h14; wdata1 = '0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      chk($sformatf("thr_aok_t%0d", t), 32'(aok1), (t % 3 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("thr_dok_t%0d", t), 32'(dok1), (t >= 3 && t % 3 == 0) ? 32'd1 : 32'd0);
      if (t >= 3 && t % 3 == 0) chk($sformatf("thr_data_t%0d", t), rd1, 32'hBEEF_0005);
    end
    @(posedge clk);
    #1;
    req1 = 1'b0;
    idle(6);

    // Reset mid-flight: two reads in flight on u2, one reset cycle carrying
    // a write that must not land.
    drive(0, 1'b0, 4'h0, 32'h4, 32'h0);
    drive(0, 1'b0, 4'h0, 32'h8, 32'h0);
    rst_b = 1'b0;
    req0 = 1'b1; wr0 = 1'b1; strb0 = 4'hF; addr0 = 32'h4; wdata0 = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    req0 = 1'b0; wr0 = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_dok2_t%0d", t), 32'(dok2), 32'd0);
    end
    @(posedge clk);
    #1;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h4;
    @(negedge clk);
    chk("post_rst_aok2", 32'(aok2), 32'd1);
    chk("post_rst_aok0", 32'(aok0), 32'd1);
    @(posedge clk);
    #1;
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_rd0", rd0, 32'hC0DE_0001);
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_dok2", 32'(dok2), 32'd1);
    chk("post_rst_rd2", rd2, 32'hC0DE_0001);
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
